// File: rtl/field_packer.sv
// Packs a stream of VW-bit values into SLOTS consecutive (VW+1)-bit slots and emits words on a valid/ready port.
// Optional slot parity tag enabled by defining FIELD_PACKER_PARITY_EN.
module field_packer #(
  parameter int SLOTS = 4,
  parameter int VW    = 3
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [VW-1:0]                i_data,
  input  logic                         i_valid,
  output logic                         o_ready,
  input  logic                         i_flush,
  output logic [SLOTS*(VW+1)-1:0]      o_data,
  output logic [$clog2(SLOTS+1)-1:0]   o_count,
  output logic                         o_valid,
  input  logic                         i_ready
);

  localparam int SW = VW + 1;
  localparam int WW = SLOTS * SW;
  localparam int CW = $clog2(SLOTS + 1);

  // Tag bit stored above the value in each filled slot.
  function automatic logic slot_tag(input logic [VW-1:0] v);
`ifdef FIELD_PACKER_PARITY_EN
    return ^v;
`else
    return 1'b0;
`endif
  endfunction

  logic [WW-1:0] acc_r;
  logic [CW-1:0] idx_r;
  logic          pending_r;

  logic [WW-1:0] acc_next_s;
  logic [CW-1:0] cnt_next_s;
  logic          accept_s;
  logic          want_xfer_s;
  logic          xfer_s;

  assign o_ready  = ~pending_r;
  assign accept_s = i_valid & ~pending_r;
  assign xfer_s   = want_xfer_s & (~o_valid | i_ready);

  // Next accumulator contents and fill count, and whether a word is ready to leave.
  always_comb begin
    acc_next_s  = acc_r;
    cnt_next_s  = idx_r + {{(CW-1){1'b0}}, accept_s};
    want_xfer_s = 1'b0;
    for (int k = 0; k < SLOTS; k++) begin
      if (accept_s && (idx_r == CW'(k))) begin
        acc_next_s[k*SW +: SW] = {slot_tag(i_data), i_data};
      end else begin
        acc_next_s[k*SW +: SW] = acc_r[k*SW +: SW];
      end
    end
    // A held word always wants out; otherwise only a completed word or a non-empty flush.
    if (pending_r) begin
      want_xfer_s = 1'b1;
    end else if (accept_s && (idx_r == CW'(SLOTS - 1))) begin
      want_xfer_s = 1'b1;
    end else if (i_flush && (cnt_next_s != {CW{1'b0}})) begin
      want_xfer_s = 1'b1;
    end else begin
      want_xfer_s = 1'b0;
    end
  end

  // Accumulator, pending flag and output register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc_r     <= {WW{1'b0}};
      idx_r     <= {CW{1'b0}};
      pending_r <= 1'b0;
      o_data    <= {WW{1'b0}};
      o_count   <= {CW{1'b0}};
      o_valid   <= 1'b0;
    end else if (xfer_s) begin
      o_data    <= acc_next_s;
      o_count   <= cnt_next_s;
      o_valid   <= 1'b1;
      acc_r     <= {WW{1'b0}};
      idx_r     <= {CW{1'b0}};
      pending_r <= 1'b0;
    end else begin
      if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end else begin
        o_valid <= o_valid;
      end
      acc_r     <= acc_next_s;
      idx_r     <= cnt_next_s;
      pending_r <= want_xfer_s;
    end
  end

endmodule

// File: tb/tb_field_packer.sv
// Directed bench for field_packer: a value-list/word-queue model checked every cycle plus literal pins.
module tb_field_packer;

  localparam int SLOTS = 4;
  localparam int VW    = 3;

`ifdef FIELD_PACKER_PARITY_EN
  localparam logic [15:0] W_PACK  = 16'hA3CC;
  localparam logic [15:0] W_PART  = 16'h0095;
  localparam logic [15:0] W_1234  = 16'hC3A9;
  localparam logic [15:0] W_5670  = 16'h0F65;
  localparam logic [15:0] W_SEVEN = 16'h000F;
`else
  localparam logic [15:0] W_PACK  = 16'h2344;
  localparam logic [15:0] W_PART  = 16'h0015;
  localparam logic [15:0] W_1234  = 16'h4321;
  localparam logic [15:0] W_5670  = 16'h0765;
  localparam logic [15:0] W_SEVEN = 16'h0007;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [2:0]  i_data = 3'd0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic        i_flush = 1'b0;
  logic [15:0] o_data;
  logic [2:0]  o_count;
  logic        o_valid;
  logic        i_ready = 1'b0;

  int checks = 0;
  int failures = 0;

  int          vals[$];
  logic [15:0] expq[$];
  int          cntq[$];

  field_packer #(.SLOTS(SLOTS), .VW(VW)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_data(i_data), .i_valid(i_valid),
    .o_ready(o_ready), .i_flush(i_flush), .o_data(o_data), .o_count(o_count),
    .o_valid(o_valid), .i_ready(i_ready)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] build_word(input int n);
    logic [15:0] w = 16'h0000;
    for (int k = 0; k < n; k++) begin
      logic [2:0] v = vals[k][2:0];
      logic       t;
`ifdef FIELD_PACKER_PARITY_EN
      t = ^v;
`else
      t = 1'b0;
`endif
      w = w | ({12'h000, t, v} << (4 * k));
    end
    return w;
  endfunction

  // Reference model: collect accepted values, emit words in order, check the output each cycle.
  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vals.delete();
      expq.delete();
      cntq.delete();
    end else begin
      chk("ready_vs_backlog", {31'd0, o_ready}, {31'd0, (expq.size() - int'(o_valid)) == 0});
      if (o_valid) begin
        if (expq.size() == 0) begin
          chk("unexpected_word", {16'h0000, o_data}, 32'hFFFF_FFFF);
        end else begin
          chk("model_data", {16'h0000, o_data}, {16'h0000, expq[0]});
          chk("model_count", {29'd0, o_count}, cntq[0]);
          if (i_ready) begin
            void'(expq.pop_front());
            void'(cntq.pop_front());
          end
        end
      end
      if (i_valid && o_ready) vals.push_back(int'(i_data));
      if (vals.size() == SLOTS || (i_flush && o_ready && vals.size() > 0)) begin
        expq.push_back(build_word(vals.size()));
        cntq.push_back(vals.size());
        vals.delete();
      end
    end
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic push(input logic [2:0] v);
    i_valid = 1'b1;
    i_data  = v;
    step();
    i_valid = 1'b0;
  endtask

  initial begin
    logic [2:0] stall_vals[8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
    logic [2:0] pack_vals[4]  = '{3'd4, 3'd4, 3'd3, 3'd2};

    #2;
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_data", {16'h0000, o_data}, 32'd0);
    chk("rst_count", {29'd0, o_count}, 32'd0);
    #10 i_rst_n = 1'b1;
    chk("rst_ready", {31'd0, o_ready}, 32'd1);

    // Full word, consecutive accepts.
    i_ready = 1'b1;
    step();
    foreach (pack_vals[i]) push(pack_vals[i]);
    chk("pack_valid", {31'd0, o_valid}, 32'd1);
    chk("pack_data", {16'h0000, o_data}, {16'h0000, W_PACK});
    chk("pack_count", {29'd0, o_count}, 32'd4);
    chk("pack_ready", {31'd0, o_ready}, 32'd1);

    // Partial flush then an empty flush.
    push(3'd5);
    push(3'd1);
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    chk("part_data", {16'h0000, o_data}, {16'h0000, W_PART});
    chk("part_count", {29'd0, o_count}, 32'd2);
    step();
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    chk("empty_flush", {31'd0, o_valid}, 32'd0);
    step();
    chk("empty_flush2", {31'd0, o_valid}, 32'd0);

    // Back-pressure: second word held pending.
    i_ready = 1'b0;
    foreach (stall_vals[i]) push(stall_vals[i]);
    chk("stall_ready", {31'd0, o_ready}, 32'd0);
    chk("stall_data", {16'h0000, o_data}, {16'h0000, W_1234});
    step();
    step();
    chk("stall_hold", {16'h0000, o_data}, {16'h0000, W_1234});
    chk("stall_hold_v", {31'd0, o_valid}, 32'd1);
    i_ready = 1'b1;
    step();
    chk("stall_next", {16'h0000, o_data}, {16'h0000, W_5670});
    chk("stall_next_v", {31'd0, o_valid}, 32'd1);
    chk("stall_ready_back", {31'd0, o_ready}, 32'd1);
    step();
    chk("stall_drained", {31'd0, o_valid}, 32'd0);

    // Flush coinciding with an accept at index 0.
    i_flush = 1'b1;
    push(3'd7);
    i_flush = 1'b0;
    chk("fa_data", {16'h0000, o_data}, {16'h0000, W_SEVEN});
    chk("fa_count", {29'd0, o_count}, 32'd1);
    step();

    // Asynchronous reset with a held word and a partial word.
    i_ready = 1'b0;
    foreach (stall_vals[i]) if (i < 7) push(stall_vals[i]);
    chk("pre_rst_valid", {31'd0, o_valid}, 32'd1);
    #3 i_rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, o_valid}, 32'd0);
    chk("mid_rst_data", {16'h0000, o_data}, 32'd0);
    chk("mid_rst_count", {29'd0, o_count}, 32'd0);
    chk("mid_rst_ready", {31'd0, o_ready}, 32'd1);
    #1 i_rst_n = 1'b1;
    i_ready = 1'b1;
    step();
    foreach (stall_vals[i]) if (i < 4) push(stall_vals[i]);
    chk("post_rst_data", {16'h0000, o_data}, {16'h0000, W_1234});
    chk("post_rst_count", {29'd0, o_count}, 32'd4);
    step();
    step();
    chk("queue_drained", expq.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
